// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared types and step constants for the interrupt sequencer
//
// Contents:
//   src_t   : interrupt source (RESET, NMI, IRQ, BRK), encoded 0..3
//   state_t : sequencer state (IDLE, SEQ)
//   STEP_*  : step numbers of the 7-step interrupt sequence
package int_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    NMI   = 2'd1,
    IRQ   = 2'd2,
    BRK   = 2'd3
  } src_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;

  localparam logic [2:0] STEP_PCH = 3'd2;
  localparam logic [2:0] STEP_PCL = 3'd3;
  localparam logic [2:0] STEP_P   = 3'd4;
  localparam logic [2:0] STEP_VLO = 3'd5;
  localparam logic [2:0] STEP_VHI = 3'd6;

endpackage

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - multi-flop synchroniser for an asynchronous active-low pin
//
// Ports:
//   clk  : system clock
//   nrst : asynchronous active-low reset; every stage resets to 1 (pin inactive)
//   d    : asynchronous pin input
//   q    : synchronised output, SYNC_STAGES cycles behind d
module pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - RESET/NMI/IRQ/BRK arbitration and 7-step interrupt sequence
//
// Optional feature: define NMI_HIJACK_EN to let an NMI edge taken during an
// IRQ/BRK sequence (up to the P push) redirect the vector fetch to NMI.
//
// Ports:
//   clk, nrst      : clock, asynchronous active-low reset
//   nmi_n, irq_n   : asynchronous interrupt pins (NMI falling-edge, IRQ level)
//   psr_i          : I flag from the status register
//   instr_boundary : control unit at opcode-fetch decision cycle
//   brk_decoded    : current opcode is BRK (qualified by instr_boundary)
//   php_push       : control unit pushing P for PHP
//   step_en        : advance the sequence one step
//   int_active     : sequence in progress
//   seq_step       : current step 0..6
//   src            : 0=RESET 1=NMI 2=IRQ 3=BRK
//   vec_addr       : vector address, +1 during step 6
//   push_en        : stack write strobe during steps 2..4 (not for RESET)
//   break_set      : B bit high on pushed P (combinational)
//   set_i          : one-cycle I-set pulse leaving step 5
//   seq_done       : one-cycle pulse at end of step 6
module interrupt_sequencer
  import int_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA,
  parameter logic [15:0] RST_VEC     = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        psr_i,
  input  logic        instr_boundary,
  input  logic        brk_decoded,
  input  logic        php_push,
  input  logic        step_en,
  output logic        int_active,
  output logic [2:0]  seq_step,
  output logic [1:0]  src,
  output logic [15:0] vec_addr,
  output logic        push_en,
  output logic        break_set,
  output logic        set_i,
  output logic        seq_done
);

  logic   nmi_s;
  logic   irq_s;
  logic   nmi_prev_q;
  logic   nmi_edge;
  logic   nmi_pending_q;
  logic   nmi_clear;
  logic   irq_req;
  logic   brk_flag;

  state_t     state_q, state_d;
  src_t       src_q, src_d;
  logic [2:0] step_q, step_d;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (nmi_n),
    .q    (nmi_s)
  );

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (irq_n),
    .q    (irq_s)
  );

  assign nmi_edge = nmi_prev_q & ~nmi_s;
  assign irq_req  = ~irq_s & ~psr_i;

  // NMI is consumed when leaving the vector-low step; a fresh edge in the
  // same cycle takes priority so it is not lost.
  assign nmi_clear = (state_q == SEQ) && (step_q == STEP_VLO) && step_en && (src_q == NMI);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else begin
      nmi_prev_q    <= nmi_s;
      nmi_pending_q <= nmi_edge | (nmi_pending_q & ~nmi_clear);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= SEQ;
      src_q   <= RESET;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      step_q  <= step_d;
    end
  end

`ifdef NMI_HIJACK_EN
  // Remembers that the sequence started as BRK so the pushed P keeps B=1
  // even after an NMI has redirected the source.
  logic orig_brk_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      orig_brk_q <= 1'b0;
    end else if (state_q == IDLE && state_d == SEQ) begin
      orig_brk_q <= (src_d == BRK);
    end
  end

  assign brk_flag = orig_brk_q;
`else
  assign brk_flag = (src_q == BRK);
`endif

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    step_d   = step_q;
    seq_done = 1'b0;
    set_i    = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_boundary) begin
          if (nmi_pending_q) begin
            src_d   = NMI;
            step_d  = 3'd0;
            state_d = SEQ;
          end else if (irq_req) begin
            src_d   = IRQ;
            step_d  = 3'd0;
            state_d = SEQ;
          end else if (brk_decoded) begin
            src_d   = BRK;
            step_d  = 3'd0;
            state_d = SEQ;
          end
        end
      end

      SEQ: begin
`ifdef NMI_HIJACK_EN
        if (nmi_edge && (src_q == IRQ || src_q == BRK) && step_q <= STEP_P) begin
          src_d = NMI;
        end
`endif
        if (step_en) begin
          if (step_q == STEP_VHI) begin
            seq_done = 1'b1;
            step_d   = 3'd0;
            state_d  = IDLE;
          end else begin
            step_d = step_q + 3'd1;
          end
          if (step_q == STEP_VLO) begin
            set_i = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    case (src_q)
      RESET:   vec_addr = RST_VEC;
      NMI:     vec_addr = NMI_VEC;
      default: vec_addr = IRQ_VEC;
    endcase
    if (step_q == STEP_VHI) begin
      vec_addr = vec_addr + 16'd1;
    end
  end

  assign int_active = (state_q == SEQ);
  assign seq_step   = step_q;
  assign src        = src_q;
  assign push_en    = (state_q == SEQ) && (step_q >= STEP_PCH) && (step_q <= STEP_P) && (src_q != RESET);
  assign break_set  = php_push | ((state_q == SEQ) && (step_q == STEP_P) && brk_flag);

endmodule
